branch_target_buffer: RTL and testbench

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

---
 rtl/branch_target_buffer_pkg.sv | 26 ++
 rtl/branch_target_buffer_lru_select.sv | 43 ++++
 rtl/branch_target_buffer.sv | 181 ++++++++++++++++++
 tb/tb_branch_target_buffer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/branch_target_buffer_pkg.sv
// Shared types and constants for the branch target buffer.
// btb_entry_t holds the per-entry state whose width does not depend on module
// parameters (valid bit, 2-bit direction counter); tag, target and age widths
// follow WIDTH/SIZE and live in parallel per-field arrays inside the top.
package branch_target_buffer_pkg;

  localparam logic [1:0] CNT_MIN     = 2'd0;
  localparam logic [1:0] CNT_WEAK_NT = 2'd1;
  localparam logic [1:0] CNT_WEAK_T  = 2'd2;
  localparam logic [1:0] CNT_MAX     = 2'd3;

  typedef struct packed {
    logic       valid;
    logic [1:0] cnt;
  } btb_entry_t;

  // Saturating 2-bit direction counter step.
  function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && cnt != CNT_MAX)       res = cnt + 2'd1;
    else if (!taken && cnt != CNT_MIN) res = cnt - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/branch_target_buffer_lru_select.sv
// Victim selection for allocation: lowest-index invalid entry, otherwise the
// entry holding the maximum age (least recently touched).
// Ports:
//   valid  - per-entry valid bits
//   age    - per-entry ages, packed, entry i at [i*AGE_W +: AGE_W]
//   victim - index of the entry to allocate into
module btb_lru_select #(
  parameter int SIZE  = 8,
  parameter int AGE_W = $clog2(SIZE)
) (
  input  logic [SIZE-1:0]       valid,
  input  logic [SIZE*AGE_W-1:0] age,
  output logic [AGE_W-1:0]      victim
);

  logic             found;
  logic [AGE_W-1:0] max_age;
  logic [AGE_W-1:0] cur_age;

  always_comb begin
    victim  = '0;
    found   = 1'b0;
    max_age = age[AGE_W-1:0];
    cur_age = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (!valid[i] && !found) begin
        victim = AGE_W'(i);
        found  = 1'b1;
      end
    end
    if (!found) begin
      // Strict compare keeps the lowest index on a tie.
      for (int unsigned i = 1; i < SIZE; i++) begin
        cur_age = age[i*AGE_W +: AGE_W];
        if (cur_age > max_age) begin
          max_age = cur_age;
          victim  = AGE_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Fully associative branch target buffer with 2-bit direction counters and
// age-based replacement. Optional statistics under BRANCH_TARGET_BUFFER_STATS_EN.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   lookup_en, pc       - IF-stage lookup (lookup_en only qualifies stats)
//   predict_jump        - hit and counter predicts taken
//   jump_addr           - target of hit entry, 0 on miss
//   ex_branch, ex_pc, ex_target, ex_taken - EX-stage resolution / update
//   flush               - synchronous invalidate of all entries
//   stat_hits, stat_updates - saturating statistics (0 when stats disabled)
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SIZE   = 8,
  parameter int STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_en,
  input  logic [WIDTH-1:0]  pc,
  output logic              predict_jump,
  output logic [WIDTH-1:0]  jump_addr,
  input  logic              ex_branch,
  input  logic [WIDTH-1:0]  ex_pc,
  input  logic [WIDTH-1:0]  ex_target,
  input  logic              ex_taken,
  input  logic              flush,
  output logic [STAT_W-1:0] stat_hits,
  output logic [STAT_W-1:0] stat_updates
);

  localparam int AGE_W = $clog2(SIZE);

  btb_entry_t       ent_q [SIZE];
  btb_entry_t       ent_d [SIZE];
  logic [WIDTH-1:0] tag_q [SIZE];
  logic [WIDTH-1:0] tag_d [SIZE];
  logic [WIDTH-1:0] tgt_q [SIZE];
  logic [WIDTH-1:0] tgt_d [SIZE];
  logic [AGE_W-1:0] age_q [SIZE];
  logic [AGE_W-1:0] age_d [SIZE];

  logic [SIZE-1:0]       valid_vec;
  logic [SIZE*AGE_W-1:0] age_flat;
  logic [AGE_W-1:0]      victim;

  logic             hit;
  logic [1:0]       hit_cnt;
  logic [WIDTH-1:0] hit_tgt;

  logic             upd_hit;
  logic [AGE_W-1:0] upd_idx;
  logic [AGE_W-1:0] sel_idx;
  logic [AGE_W-1:0] old_age;

  always_comb begin
    valid_vec = '0;
    age_flat  = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      valid_vec[i]                   = ent_q[i].valid;
      age_flat[i*AGE_W +: AGE_W]     = age_q[i];
    end
  end

  btb_lru_select #(
    .SIZE  (SIZE),
    .AGE_W (AGE_W)
  ) u_lru_select (
    .valid  (valid_vec),
    .age    (age_flat),
    .victim (victim)
  );

  // Lookup reads registered state only; tags are unique so OR-merge is exact.
  always_comb begin
    hit     = 1'b0;
    hit_cnt = '0;
    hit_tgt = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (ent_q[i].valid && tag_q[i] == pc) begin
        hit     = 1'b1;
        hit_cnt = hit_cnt | ent_q[i].cnt;
        hit_tgt = hit_tgt | tgt_q[i];
      end
    end
    predict_jump = hit && (hit_cnt >= CNT_WEAK_T);
    jump_addr    = hit_tgt;
  end

  always_comb begin
    upd_hit = 1'b0;
    upd_idx = '0;
    for (int unsigned i = 0; i < SIZE; i++) begin
      if (ent_q[i].valid && tag_q[i] == ex_pc) begin
        upd_hit = 1'b1;
        upd_idx = AGE_W'(i);
      end
    end
    sel_idx = upd_hit ? upd_idx : victim;
    // A fresh allocation ages every valid entry, as if it came from the oldest slot.
    old_age = upd_hit ? age_q[upd_idx] : AGE_W'(SIZE - 1);

    ent_d = ent_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    age_d = age_q;
    if (flush) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        ent_d[i].valid = 1'b0;
        age_d[i]       = '0;
      end
    end else if (ex_branch) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        if (AGE_W'(i) == sel_idx) begin
          ent_d[i].valid = 1'b1;
          tag_d[i]       = ex_pc;
          age_d[i]       = '0;
          if (upd_hit) begin
            ent_d[i].cnt = cnt_next(ent_q[i].cnt, ex_taken);
            if (ex_taken) tgt_d[i] = ex_target;
          end else begin
            ent_d[i].cnt = ex_taken ? CNT_WEAK_T : CNT_WEAK_NT;
            tgt_d[i]     = ex_target;
          end
        end else if (ent_q[i].valid && age_q[i] < old_age) begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        ent_q[i] <= '0;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        age_q[i] <= '0;
      end
    end else begin
      ent_q <= ent_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      age_q <= age_d;
    end
  end

`ifdef BRANCH_TARGET_BUFFER_STATS_EN
  logic [STAT_W-1:0] stat_hits_q, stat_hits_d;
  logic [STAT_W-1:0] stat_updates_q, stat_updates_d;

  always_comb begin
    stat_hits_d    = stat_hits_q;
    stat_updates_d = stat_updates_q;
    if (lookup_en && hit && stat_hits_q != '1)
      stat_hits_d = stat_hits_q + STAT_W'(1);
    if (ex_branch && !flush && stat_updates_q != '1)
      stat_updates_d = stat_updates_q + STAT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_hits_q    <= '0;
      stat_updates_q <= '0;
    end else begin
      stat_hits_q    <= stat_hits_d;
      stat_updates_q <= stat_updates_d;
    end
  end

  assign stat_hits    = stat_hits_q;
  assign stat_updates = stat_updates_q;
`else
  logic unused_stats;
  assign unused_stats = lookup_en;
  assign stat_hits    = '0;
  assign stat_updates = '0;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (WIDTH=32, SIZE=8,
// STAT_W=2). Statistics expectations follow BRANCH_TARGET_BUFFER_STATS_EN.
module tb_branch_target_buffer;

`ifdef BRANCH_TARGET_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        lookup_en;
  logic [31:0] pc;
  logic        predict_jump;
  logic [31:0] jump_addr;
  logic        ex_branch;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;
  logic        flush;
  logic [1:0]  stat_hits;
  logic [1:0]  stat_updates;

  int n_checks;
  int n_fail;

  branch_target_buffer #(
    .WIDTH  (32),
    .SIZE   (8),
    .STAT_W (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .lookup_en    (lookup_en),
    .pc           (pc),
    .predict_jump (predict_jump),
    .jump_addr    (jump_addr),
    .ex_branch    (ex_branch),
    .ex_pc        (ex_pc),
    .ex_target    (ex_target),
    .ex_taken     (ex_taken),
    .flush        (flush),
    .stat_hits    (stat_hits),
    .stat_updates (stat_updates)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] p);
    pc = p;
    #1;
  endtask

  task automatic upd(input logic [31:0] p, input logic [31:0] t, input logic tk);
    ex_pc     = p;
    ex_target = t;
    ex_taken  = tk;
    ex_branch = 1'b1;
    tick();
    ex_branch = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    lookup_en = 1'b0;
    pc        = 32'h10;
    ex_branch = 1'b0;
    ex_pc     = '0;
    ex_target = '0;
    ex_taken  = 1'b0;
    flush     = 1'b0;
    #2;
    check_eq("rst_pj", 64'(predict_jump), 64'd0);
    check_eq("rst_ja", 64'(jump_addr), 64'd0);
    check_eq("rst_sh", 64'(stat_hits), 64'd0);
    check_eq("rst_su", 64'(stat_updates), 64'd0);
    tick();
    rst = 1'b1;

    look(32'h10);
    check_eq("empty_pj", 64'(predict_jump), 64'd0);
    check_eq("empty_ja", 64'(jump_addr), 64'd0);

    upd(32'h10, 32'h40, 1'b1);
    look(32'h10);
    check_eq("alloc_pj", 64'(predict_jump), 64'd1);
    check_eq("alloc_ja", 64'(jump_addr), 64'h40);
    check_eq("alloc_su", 64'(stat_updates), sx(1));

    // Flush beats a simultaneous update.
    flush = 1'b1;
    upd(32'h50, 32'h60, 1'b1);
    flush = 1'b0;
    look(32'h10);
    check_eq("flush_ja10", 64'(jump_addr), 64'd0);
    check_eq("flush_pj10", 64'(predict_jump), 64'd0);
    look(32'h50);
    check_eq("flush_ja50", 64'(jump_addr), 64'd0);
    check_eq("flush_su", 64'(stat_updates), sx(1));

    upd(32'h10, 32'h40, 1'b1);
    check_eq("su_2", 64'(stat_updates), sx(2));
    upd(32'h10, 32'h99, 1'b0);
    upd(32'h10, 32'h99, 1'b0);
    look(32'h10);
    check_eq("nt2_pj", 64'(predict_jump), 64'd0);
    check_eq("nt2_ja", 64'(jump_addr), 64'h40);
    check_eq("su_sat", 64'(stat_updates), sx(3));
    // Counter at 0: NT holds 0, then two taken -> 2.
    upd(32'h10, 32'h99, 1'b0);
    upd(32'h10, 32'h44, 1'b1);
    upd(32'h10, 32'h44, 1'b1);
    look(32'h10);
    check_eq("floor_pj", 64'(predict_jump), 64'd1);
    check_eq("floor_ja", 64'(jump_addr), 64'h44);
    check_eq("su_hold", 64'(stat_updates), sx(3));

    flush = 1'b1;
    tick();
    flush = 1'b0;

    for (int i = 0; i < 8; i++) upd(32'(i * 4), 32'h1000 + 32'(i * 4), 1'b1);
    upd(32'h00, 32'h1000, 1'b1);
    upd(32'h100, 32'h2000, 1'b1);
    look(32'h04);
    check_eq("evict_ja04", 64'(jump_addr), 64'd0);
    check_eq("evict_pj04", 64'(predict_jump), 64'd0);
    look(32'h00);
    check_eq("keep_pj00", 64'(predict_jump), 64'd1);
    check_eq("keep_ja00", 64'(jump_addr), 64'h1000);
    look(32'h100);
    check_eq("new_pj100", 64'(predict_jump), 64'd1);
    check_eq("new_ja100", 64'(jump_addr), 64'h2000);
    look(32'h08);
    check_eq("keep_ja08", 64'(jump_addr), 64'h1008);

    // 0x00 is at 3: taken holds 3, two NT -> 1.
    upd(32'h00, 32'h1000, 1'b1);
    upd(32'h00, 32'h1000, 1'b0);
    upd(32'h00, 32'h1000, 1'b0);
    look(32'h00);
    check_eq("ceil_pj", 64'(predict_jump), 64'd0);
    check_eq("ceil_ja", 64'(jump_addr), 64'h1000);

    // Same-cycle lookup sees pre-update state.
    pc        = 32'h20;
    ex_pc     = 32'h20;
    ex_target = 32'h300;
    ex_taken  = 1'b1;
    ex_branch = 1'b1;
    #1;
    check_eq("same_pj", 64'(predict_jump), 64'd0);
    check_eq("same_ja", 64'(jump_addr), 64'd0);
    tick();
    ex_branch = 1'b0;
    #1;
    check_eq("next_pj", 64'(predict_jump), 64'd1);
    check_eq("next_ja", 64'(jump_addr), 64'h300);

    lookup_en = 1'b1;
    look(32'h20);
    tick();
    tick();
    check_eq("sh_2", 64'(stat_hits), sx(2));
    look(32'h04);
    tick();
    check_eq("sh_miss", 64'(stat_hits), sx(2));
    look(32'h20);
    tick();
    tick();
    tick();
    check_eq("sh_sat", 64'(stat_hits), sx(3));
    lookup_en = 1'b0;

    // Asynchronous reset in the middle of an update.
    ex_pc     = 32'h400;
    ex_target = 32'h500;
    ex_taken  = 1'b1;
    ex_branch = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_eq("mrst_pj", 64'(predict_jump), 64'd0);
    check_eq("mrst_ja", 64'(jump_addr), 64'd0);
    check_eq("mrst_sh", 64'(stat_hits), 64'd0);
    check_eq("mrst_su", 64'(stat_updates), 64'd0);
    tick();
    rst       = 1'b1;
    ex_branch = 1'b0;
    look(32'h400);
    check_eq("post_ja400", 64'(jump_addr), 64'd0);
    look(32'h20);
    check_eq("post_ja20", 64'(jump_addr), 64'd0);
    upd(32'h20, 32'h500, 1'b1);
    look(32'h20);
    check_eq("post_pj", 64'(predict_jump), 64'd1);
    check_eq("post_ja", 64'(jump_addr), 64'h500);
    check_eq("post_su", 64'(stat_updates), sx(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
